ahblite_sram_slave: RTL and testbench

AHB-Lite responder that terminates one slave port of the AHB-Lite interconnect and backs it with an on-chip word-addressed memory. It decodes address and data phases, inserts a configurable number of wait states, generates byte-lane writes from HSIZE/HADDR, and returns the two-cycle ERROR response for illegal accesses. It serves as the default memory slave on the interconnect and as the reference responder for interconnect verification.

---
 rtl/ahblite_sram_slave.sv | 85 ++++++++
 tb/tb_ahblite_sram_slave.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ahblite_sram_slave.sv
// ahblite_sram_slave: AHB-Lite responder over word-addressed SRAM; ports: clk/rst, AHB-Lite slave inputs (_i), hreadyout_o/hresp_o/hrdata_o.
module ahblite_sram_slave #(
  parameter int AHB_AW    = 32,
  parameter int AHB_DW    = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int WAIT_CYC  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel_i,
  input  logic [AHB_AW-1:0] haddr_i,
  input  logic              hwrite_i,
  input  logic [1:0]        htrans_i,
  input  logic [2:0]        hsize_i,
  input  logic [2:0]        hburst_i,
  input  logic [3:0]        hprot_i,
  input  logic              hmastlock_i,
  input  logic [AHB_DW-1:0] hwdata_i,
  input  logic              hready_i,
  output logic              hreadyout_o,
  output logic              hresp_o,
  output logic [AHB_DW-1:0] hrdata_o
);
  localparam int IW = $clog2(MEM_DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, be_q, be_d, be;
  logic pend_q, pend_d, wr_q, wr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [AHB_DW-1:0] mem [MEM_DEPTH];
  logic accept, illegal, done, unused;
  assign unused = ^{hburst_i, hprot_i, hmastlock_i, htrans_i[0], haddr_i[AHB_AW-1:16]};
  assign illegal = ({1'b0, haddr_i[15:0]} >= 17'(MEM_DEPTH * 4)) || (hsize_i > 3'd2) ||
                   (hsize_i == 3'd1 && haddr_i[0]) || (hsize_i == 3'd2 && |haddr_i[1:0]);
  assign be = hsize_i == 3'd0 ? 4'b0001 << haddr_i[1:0] :
              hsize_i == 3'd1 ? (haddr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign done = pend_q && cnt_q == 4'd0;
  assign hreadyout_o = state_q != ERR1 && (!pend_q || cnt_q == 4'd0);
  assign hresp_o = state_q == ERR1 || state_q == ERR2;
  assign accept = hsel_i && hready_i && htrans_i[1] && hreadyout_o;
  assign hrdata_o = done && !wr_q ? mem[idx_q] : '0;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pend_d = pend_q;
    wr_d = wr_q;
    idx_d = idx_q;
    be_d = be_q;
    if (state_q == ERR1) state_d = ERR2;
    else if (pend_q && cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
    else if (accept) begin
      state_d = illegal ? ERR1 : (WAIT_CYC == 0 ? IDLE : WAIT);
      pend_d = !illegal;
      cnt_d = illegal ? 4'd0 : 4'(WAIT_CYC);
      wr_d = hwrite_i;
      idx_d = haddr_i[IW+1:2];
      be_d = be;
    end else begin
      state_d = IDLE;
      pend_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pend_q <= 1'b0;
      wr_q <= 1'b0;
      idx_q <= '0;
      be_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      wr_q <= wr_d;
      idx_q <= idx_d;
      be_q <= be_d;
    end
  end
  // a write still pending when reset hits is dropped
  always_ff @(posedge clk)
    if (!rst && done && wr_q)
      for (int b = 0; b < 4; b++)
        if (be_q[b]) mem[idx_q][8*b +: 8] <= hwdata_i[8*b +: 8];
endmodule

// File: tb/tb_ahblite_sram_slave.sv
// tb_ahblite_sram_slave: randomized bench for ahblite_sram_slave with WAIT_CYC = 0, 3, 2 against a transfer-level model.
module tb_ahblite_sram_slave;
  localparam int DEPTH = 64;
  typedef struct {
    bit rdy;
    bit rsp;
    int kind;
    int idx;
    logic [31:0] mask;
    logic [31:0] wd;
  } ent_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, hr_force, hmastlock;
  logic [2:0] hburst;
  logic [3:0] hprot;
  logic hsel[3], hwrite[3], hready[3], hro[3], hrsp[3];
  logic [31:0] haddr[3], hwdata[3], hrd[3];
  logic [1:0] htrans[3];
  logic [2:0] hsize[3];
  logic [31:0] mm[3][DEPTH];
  logic [31:0] last_rd, old;
  int wc[3] = '{0, 3, 2};
  int checks = 0, failures = 0, cur = 0;
  ent_t q[$];
  for (genvar i = 0; i < 3; i++) begin : g_dut
    assign hready[i] = hro[i] & hr_force;
    ahblite_sram_slave #(.MEM_DEPTH(DEPTH), .WAIT_CYC(i == 0 ? 0 : i == 1 ? 3 : 2)) u_dut (
      .clk(clk), .rst(rst), .hsel_i(hsel[i]), .haddr_i(haddr[i]), .hwrite_i(hwrite[i]),
      .htrans_i(htrans[i]), .hsize_i(hsize[i]), .hburst_i(hburst), .hprot_i(hprot),
      .hmastlock_i(hmastlock), .hwdata_i(hwdata[i]), .hready_i(hready[i]),
      .hreadyout_o(hro[i]), .hresp_o(hrsp[i]), .hrdata_o(hrd[i]));
  end
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (dut%0d t=%0t): got %h expected %h", tag, cur, $time, act, exp);
    end
  endtask
  task automatic push(input logic [31:0] a, input bit wr, input logic [2:0] sz, input logic [31:0] wd);
    int off, n;
    logic [63:0] m;
    ent_t e;
    off = int'(a[15:0]);
    if (off >= DEPTH * 4 || sz > 2 || (off % (1 << sz)) != 0) begin
      q.push_back('{0, 1, 0, 0, 0, 0});
      q.push_back('{1, 1, 0, 0, 0, 0});
    end else begin
      for (int i = 0; i < wc[cur]; i++) q.push_back('{0, 0, 0, 0, 0, 0});
      n = 1 << sz;
      m = ((64'd1 << (8 * n)) - 64'd1) << (8 * (off % 4));
      e = '{1, 0, wr ? 2 : 1, off / 4, m[31:0], wd};
      q.push_back(e);
    end
  endtask
  task automatic step(input bit sel, input logic [1:0] tr, input bit wr, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] wd, output bit acc);
    ent_t e;
    e = q.size() != 0 ? q[0] : '{1, 0, 0, 0, 0, 0};
    hsel[cur] = sel; htrans[cur] = tr; hwrite[cur] = wr; haddr[cur] = a; hsize[cur] = sz;
    hwdata[cur] = e.kind == 2 ? e.wd : $urandom;
    hburst = 3'($urandom); hprot = 4'($urandom); hmastlock = 1'($urandom);
    @(negedge clk);
    chk("hreadyout", 32'(hro[cur]), 32'(e.rdy));
    chk("hresp", 32'(hrsp[cur]), 32'(e.rsp));
    chk("hrdata", hrd[cur], e.kind == 1 ? mm[cur][e.idx] : 32'd0);
    if (e.kind == 1) last_rd = hrd[cur];
    if (e.kind == 2) mm[cur][e.idx] = (mm[cur][e.idx] & ~e.mask) | (e.wd & e.mask);
    if (q.size() != 0) void'(q.pop_front());
    acc = sel && tr[1] && e.rdy && hr_force;
    if (acc) push(a, wr, sz, wd);
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 2'b00, 0, 32'h0, 3'd0, 32'h0, acc);
  endtask
  task automatic drain();
    bit acc;
    for (int i = 0; i < 40 && q.size() != 0; i++) step(0, 2'b00, 0, 32'h0, 3'd0, 32'h0, acc);
  endtask
  task automatic xfer(input bit wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    bit acc = 0;
    for (int i = 0; i < 40 && !acc; i++) step(1, 2'b10, wr, a, sz, wd, acc);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1);
  end
  initial begin
    bit acc;
    logic [31:0] a;
    logic [2:0] sz;
    int r;
    for (int k = 0; k < 3; k++) begin
      hsel[k] = 0; hwrite[k] = 0; haddr[k] = 0; htrans[k] = 0; hsize[k] = 0; hwdata[k] = 0;
    end
    hburst = 0; hprot = 0; hmastlock = 0; hr_force = 1; rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      cur = k;
      chk("rst_ready", 32'(hro[k]), 32'd1);
      chk("rst_resp", 32'(hrsp[k]), 32'd0);
      chk("rst_rdata", hrd[k], 32'd0);
    end
    @(posedge clk);
    #1 rst = 0;
    for (int k = 0; k < 3; k++) begin
      cur = k;
      for (int i = 0; i < DEPTH; i++) xfer(1, 32'(i * 4), 3'd2, $urandom);
      xfer(1, 32'h10, 3'd2, 32'hDEADBEEF);
      xfer(0, 32'h10, 3'd2, 32'h0);
      drain();
      chk("b2b_read", last_rd, 32'hDEADBEEF);
      xfer(1, 32'h10, 3'd2, 32'h0);
      xfer(1, 32'h13, 3'd0, 32'hAAAAAAAA);
      xfer(1, 32'h10, 3'd1, 32'h12341234);
      xfer(0, 32'h10, 3'd2, 32'h0);
      drain();
      chk("lanes", last_rd, 32'hAA001234);
      old = mm[k][0];
      xfer(1, 32'h2, 3'd2, 32'h55555555);
      xfer(1, 32'(DEPTH * 4), 3'd2, 32'h66666666);
      xfer(0, 32'(DEPTH * 4), 3'd2, 32'h0);
      xfer(0, 32'h0, 3'd2, 32'h0);
      drain();
      chk("err_nowrite", last_rd, old);
      step(1, 2'b00, 1, 32'h40, 3'd2, 32'h77777777, acc);
      step(1, 2'b01, 1, 32'h40, 3'd2, 32'h77777777, acc);
      step(0, 2'b10, 1, 32'h40, 3'd2, 32'h77777777, acc);
      hr_force = 0;
      step(1, 2'b10, 1, 32'h40, 3'd2, 32'h88888888, acc);
      hr_force = 1;
      old = mm[k][16];
      xfer(0, 32'h40, 3'd2, 32'h0);
      drain();
      chk("no_change", last_rd, old);
      xfer(0, 32'h20, 3'd2, 32'h0);
      drain();
      if (wc[k] > 0) begin
        old = mm[k][12];
        xfer(1, 32'h30, 3'd2, 32'hCAFEF00D);
        rst = 1;
        idle(1);
        rst = 0;
        q.delete();
        idle(1);
        xfer(0, 32'h30, 3'd2, 32'h0);
        drain();
        chk("rst_keep", last_rd, old);
      end
      for (int t = 0; t < 150; t++) begin
        r = $urandom_range(0, 9);
        if (r == 0) step($urandom_range(0, 1) == 1, 2'($urandom_range(0, 1)), 1, $urandom, 3'd2, $urandom, acc);
        else if (r == 1) step(0, 2'b10, 1, 32'($urandom_range(0, DEPTH * 4 - 4)), 3'd2, $urandom, acc);
        else if (r == 2 && q.size() == 0) begin
          hr_force = 0;
          step(1, 2'b10, 1, 32'($urandom_range(0, DEPTH * 4 - 4)), 3'd2, $urandom, acc);
          hr_force = 1;
        end else begin
          sz = $urandom_range(0, 9) == 0 ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
          a = 32'($urandom_range(0, DEPTH * 4 + 7));
          if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz[1:0]) - 32'd1);
          a = a | ($urandom & 32'hFFFF0000);
          xfer($urandom_range(0, 1) == 1, a, sz, $urandom);
        end
      end
      drain();
      idle(2);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
